// File: rtl/codificador_de_usuario_if.sv
// Request/decision bundle between the access switches and the user-code encoder.
// The master side raises requests; the slave side returns the displayed code.
interface codificador_de_usuario_if;
    logic       Admin;
    logic       Tester;
    logic       UserReq;
    logic       Guest;
    logic       Deny;
    logic [2:0] User;
    logic       Enable;
    logic       Update;

    modport master (
        output Admin,
        output Tester,
        output UserReq,
        output Guest,
        output Deny,
        input  User,
        input  Enable,
        input  Update
    );

    modport slave (
        input  Admin,
        input  Tester,
        input  UserReq,
        input  Guest,
        input  Deny,
        output User,
        output Enable,
        output Update
    );
endinterface

// File: rtl/codificador_de_usuario.sv
// User-code encoder: synchronizes and debounces the request vector, then holds each
// displayed code for a minimum time so the 7-segment decoder never flickers.
module codificador_de_usuario #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    codificador_de_usuario_if.slave  bus
);

    localparam logic [31:0] DCNT_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] HCNT_LAST = 32'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_SHOW     = 2'd2
    } state_t;

    // Vector order {Deny, Admin, Tester, UserReq, Guest}; Deny overrides, otherwise
    // the lowest-priority requester present is the one displayed.
    function automatic logic [2:0] code_of(input logic [4:0] v);
        logic [2:0] c;
        if (v[4]) begin
            c = 3'b010;
        end else if (v[0]) begin
            c = 3'b110;
        end else if (v[1]) begin
            c = 3'b001;
        end else if (v[2]) begin
            c = 3'b011;
        end else if (v[3]) begin
            c = 3'b101;
        end else begin
            c = 3'b000;
        end
        return c;
    endfunction

    logic [4:0]  raw_s;
    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    logic [4:0]  v_s;

    state_t      state_q, state_d;
    logic [4:0]  snap_q, snap_d;
    logic [31:0] dcnt_q, dcnt_d;
    logic [31:0] hcnt_q, hcnt_d;
    logic [2:0]  user_q, user_d;
    logic        enable_q, enable_d;
    logic        update_q, update_d;

    assign raw_s = {bus.Deny, bus.Admin, bus.Tester, bus.UserReq, bus.Guest};
    assign v_s   = sync2_q;

    // Two-flop synchronizer for the asynchronous request vector.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 5'b00000;
            sync2_q <= 5'b00000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Next-state and output-load decision.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        dcnt_d   = dcnt_q;
        hcnt_d   = hcnt_q;
        user_d   = user_q;
        enable_d = enable_q;
        update_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (v_s != 5'b00000) begin
                    state_d = ST_DEBOUNCE;
                    snap_d  = v_s;
                    dcnt_d  = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DEBOUNCE: begin
                if (v_s != snap_q) begin
                    snap_d = v_s;
                    dcnt_d = 32'd0;
                end else if (dcnt_q == DCNT_LAST) begin
                    update_d = 1'b1;
                    if (snap_q == 5'b00000) begin
                        state_d  = ST_IDLE;
                        user_d   = 3'b000;
                        enable_d = 1'b0;
                    end else begin
                        state_d  = ST_SHOW;
                        hcnt_d   = 32'd0;
                        user_d   = code_of(snap_q);
                        enable_d = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 32'd1;
                end
            end

            ST_SHOW: begin
                // The hold counter saturates; only then is the input looked at again.
                if (hcnt_q != HCNT_LAST) begin
                    hcnt_d = hcnt_q + 32'd1;
                end else if (v_s != snap_q) begin
                    state_d = ST_DEBOUNCE;
                    snap_d  = v_s;
                    dcnt_d  = 32'd0;
                end else begin
                    state_d = ST_SHOW;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                snap_d   = 5'b00000;
                dcnt_d   = 32'd0;
                hcnt_d   = 32'd0;
                user_d   = 3'b000;
                enable_d = 1'b0;
            end
        endcase
    end

    // State, snapshot, counters and registered display outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            snap_q   <= 5'b00000;
            dcnt_q   <= 32'd0;
            hcnt_q   <= 32'd0;
            user_q   <= 3'b000;
            enable_q <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            dcnt_q   <= dcnt_d;
            hcnt_q   <= hcnt_d;
            user_q   <= user_d;
            enable_q <= enable_d;
            update_q <= update_d;
        end
    end

    assign bus.User   = user_q;
    assign bus.Enable = enable_q;
    assign bus.Update = update_q;

endmodule

// File: tb/tb_codificador_de_usuario.sv
// Directed bench for the user-code encoder; outputs sampled on falling edges as
// {User, Enable, Update}.
module tb_codificador_de_usuario;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    codificador_de_usuario_if bus ();

    codificador_de_usuario #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic set_inputs(input logic [4:0] v);
        {bus.Deny, bus.Admin, bus.Tester, bus.UserReq, bus.Guest} = v;
    endtask

    task automatic go_idle();
        logic [4:0] obs;
        set_inputs(5'b00000);
        repeat (40) @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b000_0_0) begin
            errors++;
            $display("FAIL go_idle: got %b expected %b", obs, 5'b000_0_0);
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        Reset = 1'b1;
        set_inputs(5'b11111);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b000_0_0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", k, obs, 5'b000_0_0);
            end
        end
        Reset = 1'b0;
        set_inputs(5'b00000);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b000_0_0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got %b expected %b", k, obs, 5'b000_0_0);
            end
        end
    endtask

    task automatic test_guest();
        logic [4:0] obs;
        set_inputs(5'b00001);
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b000_0_0) begin
                errors++;
                $display("FAIL guest_early[%0d]: got %b expected %b", k, obs, 5'b000_0_0);
            end
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b110_1_1) begin
            errors++;
            $display("FAIL guest_load: got %b expected %b", obs, 5'b110_1_1);
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b110_1_0) begin
            errors++;
            $display("FAIL guest_pulse_end: got %b expected %b", obs, 5'b110_1_0);
        end
    endtask

    task automatic test_priority_deny();
        logic [4:0] obs;
        go_idle();
        set_inputs(5'b01010);
        repeat (7) @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b001_1_1) begin
            errors++;
            $display("FAIL admin_userreq: got %b expected %b", obs, 5'b001_1_1);
        end
        repeat (10) @(negedge Clock);
        set_inputs(5'b11010);
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b001_1_0) begin
                errors++;
                $display("FAIL deny_early[%0d]: got %b expected %b", k, obs, 5'b001_1_0);
            end
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b010_1_1) begin
            errors++;
            $display("FAIL deny_load: got %b expected %b", obs, 5'b010_1_1);
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b010_1_0) begin
            errors++;
            $display("FAIL deny_pulse_end: got %b expected %b", obs, 5'b010_1_0);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] obs;
        go_idle();
        for (int i = 0; i < 6; i++) begin
            set_inputs((i % 2 == 0) ? 5'b00010 : 5'b00000);
            for (int c = 0; c < 2; c++) begin
                @(negedge Clock);
                obs = {bus.User, bus.Enable, bus.Update};
                checks++;
                if (obs !== 5'b000_0_0) begin
                    errors++;
                    $display("FAIL bounce[%0d.%0d]: got %b expected %b", i, c, obs, 5'b000_0_0);
                end
            end
        end
        set_inputs(5'b00010);
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b000_0_0) begin
                errors++;
                $display("FAIL settle_early[%0d]: got %b expected %b", k, obs, 5'b000_0_0);
            end
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b001_1_1) begin
            errors++;
            $display("FAIL settle_load: got %b expected %b", obs, 5'b001_1_1);
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b001_1_0) begin
            errors++;
            $display("FAIL settle_pulse_end: got %b expected %b", obs, 5'b001_1_0);
        end
    endtask

    task automatic test_hold_release();
        logic [4:0] obs;
        go_idle();
        set_inputs(5'b00100);
        repeat (7) @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b011_1_1) begin
            errors++;
            $display("FAIL tester_load: got %b expected %b", obs, 5'b011_1_1);
        end
        @(negedge Clock);
        set_inputs(5'b00000);
        for (int k = 2; k < 12; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b011_1_0) begin
                errors++;
                $display("FAIL tester_hold[E+%0d]: got %b expected %b", k, obs, 5'b011_1_0);
            end
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b000_0_1) begin
            errors++;
            $display("FAIL tester_release: got %b expected %b", obs, 5'b000_0_1);
        end
    endtask

    task automatic test_reset_mid_show();
        logic [4:0] obs;
        go_idle();
        set_inputs(5'b01000);
        repeat (7) @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b101_1_1) begin
            errors++;
            $display("FAIL admin_load: got %b expected %b", obs, 5'b101_1_1);
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b000_0_0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", obs, 5'b000_0_0);
        end
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            obs = {bus.User, bus.Enable, bus.Update};
            checks++;
            if (obs !== 5'b000_0_0) begin
                errors++;
                $display("FAIL post_reset[%0d]: got %b expected %b", k, obs, 5'b000_0_0);
            end
        end
        @(negedge Clock);
        obs = {bus.User, bus.Enable, bus.Update};
        checks++;
        if (obs !== 5'b101_1_1) begin
            errors++;
            $display("FAIL admin_reload: got %b expected %b", obs, 5'b101_1_1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_guest();
        test_priority_deny();
        test_bounce();
        test_hold_release();
        test_reset_mid_show();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
